mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single data-memory port between the two store stations (ST0/ST1) and the two load stations (LD0/LD1) of the Tomasulo-style backend. Each cycle it selects at most one ready requester and drives the memory port. It pulses a grant back so the station can free itself. For loads, it broadcasts the returned data on the 40-bit `loadbus` as {tag, data}, matching the add and mult result buses.

## Interface
- `MEM_LAT`, 2: memory read latency in cycles (≥1)
- `ADDR_W`, 16: memory address width
- `DATA_W`, 32: data width
- `TAG_W`, 8: result tag width; tag 0 means "no broadcast"

- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `st_req` in 2: bit i high means store station i holds a valid address and data
- `st0_addr`, `st1_addr` in ADDR_W: store addresses
- `st0_data`, `st1_data` in DATA_W: store data
- `st_gnt` out 2: one-cycle pulse, store i accepted
- `ld_req` in 2: bit i high means load station i holds a valid address
- `ld0_addr`, `ld1_addr` in ADDR_W: load addresses
- `ld0_tag`, `ld1_tag` in TAG_W: destination tags (nonzero)
- `ld_gnt` out 2: one-cycle pulse, load i accepted
- `mem_en`, `mem_we` out 1: port access strobe and write enable
- `mem_addr` out ADDR_W; `mem_wdata` out DATA_W
- `mem_rdata` in DATA_W: valid MEM_LAT cycles after the `mem_en` read cycle
- `loadbus` out TAG_W+DATA_W: {tag[39:32], data[31:0]}; all zero when idle
- `busy` out 1: at least one load is in flight

## Operation
- Eligible set in cycle N: requesters with `req` high, excluding any requester whose `gnt` is high in N. A station drops `req` one cycle after it sees `gnt`, so this masking prevents double issue.
- Load hazard: load i is ineligible while any eligible store has an address equal to load i's address (full ADDR_W compare).
- Class choice: if both classes have eligible requesters, pick the class not served last (`last_st` flag). A class with no eligible requester yields to the other class.
- Within a class, use round-robin with a per-class pointer. The pointer moves to the other station after each grant in that class.
- Hazard override: if the only eligible loads are hazard-blocked, a store is granted even if `last_st`=1.
- Grant in cycle N means the following, all visible in N+1 (registered outputs):
  - `*_gnt[i]`=1
  - `mem_en`=1
  - `mem_we`=1 for a store, 0 for a load
  - `mem_addr` = the granted address
  - `mem_wdata` = store data, or 0 for a load
- With no grant, `mem_en`=0 and `mem_we`=0. `mem_addr` and `mem_wdata` hold their last values.
- Load return path: a MEM_LAT+1-deep tag shift register.
  - A load's tag enters at its `mem_en` cycle E.
  - At cycle E+MEM_LAT, `mem_rdata` is sampled together with the tag.
  - `loadbus` = {tag, rdata} for exactly one cycle, E+MEM_LAT+1.
  - `loadbus` = 0 in all other cycles.
- At most one access per cycle, so return tags never collide; no loadbus arbitration is needed.
- `busy` = OR of the valid bits in the tag pipeline.

## Timing
- Reset (at the clk edge with `rst`=1) sets:
  - `st_gnt`=0, `ld_gnt`=0
  - `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0
  - `loadbus`=0, `busy`=0
  - both RR pointers to station 0
  - `last_st`=0, so stores win the first tie
  - tag pipeline cleared
- Reset mid-flight: in-flight loads are dropped with no broadcast. Their stations must be reset as well.
- Store latency: `req` seen in N; `gnt` and write in N+1.
- Load latency: `req` seen in N; `gnt` and read in N+1; `loadbus` in N+2+MEM_LAT (N+4 at default).
- Throughput: one access per cycle. A continuous request stream gets back-to-back `mem_en`.
- Simultaneous events:
  - Four requests: order S0, L0, S1, L1, then repeat.
  - A request arriving in the same cycle as a grant to the other station of its class is served next in that class.
- A station granted in N is ignored in N+1 even if `req` is still high. Its new request is considered from N+2.

## Test plan
- Store only: `st_req`=01, addr 0x0010, data 0xDEADBEEF -> in N+1, `st_gnt`=01, `mem_en`=1, `mem_we`=1, `mem_addr`=0x0010, `mem_wdata`=0xDEADBEEF. No second grant in N+2 when `req` drops in N+2.
- Load latency: LD0 tag 0x21, addr 0x0040, memory returns 0x12345678 -> `ld_gnt`=01 in N+1; `loadbus`=0x21_12345678 only in N+4; `busy` high in N+1..N+3.
- Arbitration: all four requesting and held until granted -> grants S0, L0, S1, L1 in consecutive cycles N+1..N+4. Every grant is a one-cycle pulse.
- Hazard: ST1 addr 0x0080 and LD0 addr 0x0080 both requesting, `last_st`=1 -> ST1 granted first, LD0 granted the next cycle. `mem_we` reads 1 then 0.
- Back-to-back loads: LD0 tag 0x05 and LD1 tag 0x06, memory returns 0xA, 0xB -> `loadbus` shows 0x05_0000000A then 0x06_0000000B in consecutive cycles.
- Reset mid-flight: `rst` asserted the cycle after a load grant -> all outputs 0, and `loadbus` stays 0 for the next 4 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between two store and two load stations,
// and broadcasts returned load data on the tagged loadbus after the memory latency.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              st_req,
    input  logic [ADDR_W-1:0]       st0_addr,
    input  logic [ADDR_W-1:0]       st1_addr,
    input  logic [DATA_W-1:0]       st0_data,
    input  logic [DATA_W-1:0]       st1_data,
    output logic [1:0]              st_gnt,
    input  logic [1:0]              ld_req,
    input  logic [ADDR_W-1:0]       ld0_addr,
    input  logic [ADDR_W-1:0]       ld1_addr,
    input  logic [TAG_W-1:0]        ld0_tag,
    input  logic [TAG_W-1:0]        ld1_tag,
    output logic [1:0]              ld_gnt,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [TAG_W+DATA_W-1:0] loadbus,
    output logic                    busy
);

    localparam int PIPE_D = MEM_LAT + 1;

    logic [1:0]              st_gnt_q, st_gnt_d;
    logic [1:0]              ld_gnt_q, ld_gnt_d;
    logic                    mem_en_q, mem_en_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
    logic                    st_ptr_q, st_ptr_d;
    logic                    ld_ptr_q, ld_ptr_d;
    logic                    last_st_q, last_st_d;
    logic [PIPE_D-1:0]       vld_q, vld_d;
    logic [TAG_W-1:0]        tag_q [PIPE_D];
    logic [TAG_W-1:0]        tag_d [PIPE_D];
    logic [TAG_W+DATA_W-1:0] loadbus_q, loadbus_d;
    logic                    busy_q, busy_d;

    logic [1:0]              st_elig_s;
    logic [1:0]              ld_hit_s;
    logic [1:0]              ld_elig_s;
    logic                    st_win_s;
    logic                    ld_win_s;
    logic                    st_idx_s;
    logic                    ld_idx_s;

    function automatic logic rr_pick(input logic [1:0] elig, input logic ptr);
        logic pick;
        if (elig[ptr]) begin
            pick = ptr;
        end else begin
            pick = ~ptr;
        end
        return pick;
    endfunction

    // Eligibility, load/store address hazard and class/station selection.
    // A store being granted this cycle no longer blocks a matching load.
    always_comb begin
        st_elig_s   = st_req & ~st_gnt_q;
        ld_hit_s[0] = (st_elig_s[0] && (st0_addr == ld0_addr)) ||
                      (st_elig_s[1] && (st1_addr == ld0_addr));
        ld_hit_s[1] = (st_elig_s[0] && (st0_addr == ld1_addr)) ||
                      (st_elig_s[1] && (st1_addr == ld1_addr));
        ld_elig_s   = ld_req & ~ld_gnt_q & ~ld_hit_s;
        st_win_s    = (|st_elig_s) && (!(|ld_elig_s) || !last_st_q);
        ld_win_s    = (|ld_elig_s) && !st_win_s;
        st_idx_s    = rr_pick(st_elig_s, st_ptr_q);
        ld_idx_s    = rr_pick(ld_elig_s, ld_ptr_q);
    end

    // Next-state of grants, memory port drive and arbitration pointers.
    always_comb begin
        st_gnt_d    = 2'b00;
        ld_gnt_d    = 2'b00;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        st_ptr_d    = st_ptr_q;
        ld_ptr_d    = ld_ptr_q;
        last_st_d   = last_st_q;
        if (st_win_s) begin
            st_gnt_d    = st_idx_s ? 2'b10 : 2'b01;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = st_idx_s ? st1_addr : st0_addr;
            mem_wdata_d = st_idx_s ? st1_data : st0_data;
            st_ptr_d    = ~st_idx_s;
            last_st_d   = 1'b1;
        end else if (ld_win_s) begin
            ld_gnt_d    = ld_idx_s ? 2'b10 : 2'b01;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = ld_idx_s ? ld1_addr : ld0_addr;
            mem_wdata_d = '0;
            ld_ptr_d    = ~ld_idx_s;
            last_st_d   = 1'b0;
        end else begin
            mem_en_d    = 1'b0;
        end
    end

    // Tag pipeline: stage k holds the tag of the read issued k cycles ago.
    always_comb begin
        vld_d    = {vld_q[PIPE_D-2:0], ld_win_s};
        tag_d[0] = ld_win_s ? (ld_idx_s ? ld1_tag : ld0_tag) : '0;
        for (int k = 1; k < PIPE_D; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        if (vld_q[MEM_LAT]) begin
            loadbus_d = {tag_q[MEM_LAT], mem_rdata};
        end else begin
            loadbus_d = '0;
        end
        busy_d = |vld_d;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_gnt_q    <= 2'b00;
            ld_gnt_q    <= 2'b00;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            st_ptr_q    <= 1'b0;
            ld_ptr_q    <= 1'b0;
            last_st_q   <= 1'b0;
            vld_q       <= '0;
            for (int k = 0; k < PIPE_D; k++) begin
                tag_q[k] <= '0;
            end
            loadbus_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            st_gnt_q    <= st_gnt_d;
            ld_gnt_q    <= ld_gnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            st_ptr_q    <= st_ptr_d;
            ld_ptr_q    <= ld_ptr_d;
            last_st_q   <= last_st_d;
            vld_q       <= vld_d;
            for (int k = 0; k < PIPE_D; k++) begin
                tag_q[k] <= tag_d[k];
            end
            loadbus_q   <= loadbus_d;
            busy_q      <= busy_d;
        end
    end

    assign st_gnt    = st_gnt_q;
    assign ld_gnt    = ld_gnt_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign loadbus   = loadbus_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: station models and a priority-list
// arbitration model predict port accesses, loadbus broadcasts and busy.
module tb_mem_port_arbiter;

    localparam int MEM_LAT = 2;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 8;
    localparam int MAXC    = 8192;

    logic        clk, rst;
    logic [1:0]  st_req, ld_req, st_gnt, ld_gnt;
    logic [15:0] st0_addr, st1_addr, ld0_addr, ld1_addr, mem_addr;
    logic [31:0] st0_data, st1_data, mem_wdata, mem_rdata;
    logic [7:0]  ld0_tag, ld1_tag;
    logic        mem_en, mem_we, busy;
    logic [39:0] loadbus;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .st_req(st_req), .st0_addr(st0_addr), .st1_addr(st1_addr),
        .st0_data(st0_data), .st1_data(st1_data), .st_gnt(st_gnt),
        .ld_req(ld_req), .ld0_addr(ld0_addr), .ld1_addr(ld1_addr),
        .ld0_tag(ld0_tag), .ld1_tag(ld1_tag), .ld_gnt(ld_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .loadbus(loadbus), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [1:0]  sg;
        logic [1:0]  lg;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } acc_t;
    typedef struct {
        int          cyc;
        logic [39:0] val;
    } lb_t;

    acc_t acc_q[$];
    lb_t  lb_q[$];
    bit   exp_busy [MAXC];

    // Fixed-content memory; directed tests override selected words.
    logic [31:0] mem_tab [logic [15:0]];
    function automatic logic [31:0] mem_rd(input logic [15:0] a);
        if (mem_tab.exists(a)) return mem_tab[a];
        return {a, ~a};
    endfunction

    // Memory responder: returns read data MEM_LAT cycles after the read strobe.
    initial begin
        logic [MEM_LAT:0] rv;
        logic [15:0]      ra [MEM_LAT+1];
        rv = '0;
        for (int k = 0; k <= MEM_LAT; k++) ra[k] = 16'h0000;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = MEM_LAT; k > 0; k--) begin
                rv[k] = rv[k-1];
                ra[k] = ra[k-1];
            end
            rv[0] = mem_en && !mem_we;
            ra[0] = mem_addr;
            if (rv[MEM_LAT]) mem_rdata = mem_rd(ra[MEM_LAT]);
            else             mem_rdata = $urandom;
        end
    end

    // Station models and reference arbitration state.
    bit          s_pend [2], l_pend [2];
    logic [15:0] s_addr [2], l_addr [2];
    logic [31:0] s_data [2];
    logic [7:0]  l_tag  [2];
    int          s_g [2], l_g [2];
    bit          rand_en = 1'b0;
    bit          rst_req = 1'b0;
    bit          m_last_st, m_sptr, m_lptr;
    bit [1:0]    m_psg, m_plg;

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 16'h0010;
            1:       return 16'h0020;
            2:       return 16'h0030;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic put_st(input int i, input logic [15:0] a, input logic [31:0] d);
        s_pend[i] = 1'b1; s_addr[i] = a; s_data[i] = d; s_g[i] = -10;
    endtask

    task automatic put_ld(input int i, input logic [15:0] a, input logic [7:0] t);
        l_pend[i] = 1'b1; l_addr[i] = a; l_tag[i] = t; l_g[i] = -10;
    endtask

    task automatic model_reset();
        m_last_st = 1'b0; m_sptr = 1'b0; m_lptr = 1'b0; m_psg = 2'b00; m_plg = 2'b00;
        for (int i = 0; i < 2; i++) begin
            s_pend[i] = 1'b0; l_pend[i] = 1'b0; s_g[i] = -10; l_g[i] = -10;
        end
    endtask

    // Walks a priority list (class order by last served, station order by pointer)
    // and grants the first eligible requester.
    task automatic model_cycle();
        bit s_ok [2], l_ok [2];
        bit found, ptr;
        int cls, st, gc, gi;
        acc_t e;
        for (int i = 0; i < 2; i++) s_ok[i] = s_pend[i] && !m_psg[i];
        for (int i = 0; i < 2; i++)
            l_ok[i] = l_pend[i] && !m_plg[i] &&
                      !((s_ok[0] && s_addr[0] == l_addr[i]) || (s_ok[1] && s_addr[1] == l_addr[i]));
        found = 1'b0; gc = 0; gi = 0;
        for (int o = 0; o < 2 && !found; o++) begin
            cls = m_last_st ? 1 - o : o;
            ptr = (cls == 0) ? m_sptr : m_lptr;
            for (int t = 0; t < 2 && !found; t++) begin
                st = (t == 0) ? int'(ptr) : 1 - int'(ptr);
                if ((cls == 0 && s_ok[st]) || (cls == 1 && l_ok[st])) begin
                    found = 1'b1; gc = cls; gi = st;
                end
            end
        end
        m_psg = 2'b00;
        m_plg = 2'b00;
        if (found) begin
            e.cyc = cyc + 1; e.sg = 2'b00; e.lg = 2'b00;
            if (gc == 0) begin
                e.sg[gi] = 1'b1; e.we = 1'b1; e.addr = s_addr[gi]; e.wdata = s_data[gi];
                m_psg[gi] = 1'b1; m_sptr = (gi == 0); m_last_st = 1'b1; s_g[gi] = cyc;
            end else begin
                e.lg[gi] = 1'b1; e.we = 1'b0; e.addr = l_addr[gi]; e.wdata = 32'h0;
                m_plg[gi] = 1'b1; m_lptr = (gi == 0); m_last_st = 1'b0; l_g[gi] = cyc;
                for (int k = 0; k <= MEM_LAT; k++) exp_busy[cyc + 1 + k] = 1'b1;
                lb_q.push_back('{cyc + MEM_LAT + 2, {l_tag[gi], mem_rd(l_addr[gi])}});
            end
            acc_q.push_back(e);
        end
    endtask

    // One cycle: stations react to earlier grants, inputs are driven, model predicts.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (s_pend[i] && s_g[i] == cyc - 2) begin s_pend[i] = 1'b0; s_g[i] = -10; end
            if (l_pend[i] && l_g[i] == cyc - 2) begin l_pend[i] = 1'b0; l_g[i] = -10; end
            if (!s_pend[i] && rand_en && $urandom_range(0, 99) < 45)
                put_st(i, rand_addr(), $urandom);
            if (!l_pend[i] && rand_en && $urandom_range(0, 99) < 45)
                put_ld(i, rand_addr(), 8'($urandom_range(1, 255)));
        end
        if (rst_req) begin
            rst = 1'b1;
            model_reset();
            while (acc_q.size() > 0 && acc_q[$].cyc > cyc) void'(acc_q.pop_back());
            while (lb_q.size() > 0 && lb_q[$].cyc > cyc) void'(lb_q.pop_back());
            for (int k = 1; k <= MEM_LAT + 3; k++) exp_busy[cyc + k] = 1'b0;
        end else begin
            rst = 1'b0;
        end
        st_req   = {s_pend[1], s_pend[0]};
        ld_req   = {l_pend[1], l_pend[0]};
        st0_addr = s_addr[0]; st1_addr = s_addr[1];
        st0_data = s_data[0]; st1_data = s_data[1];
        ld0_addr = l_addr[0]; ld1_addr = l_addr[1];
        ld0_tag  = l_tag[0];  ld1_tag  = l_tag[1];
        if (!rst_req) model_cycle();
    endtask

    // Monitor: consumes expectations whenever the port or loadbus shows activity.
    initial forever begin
        acc_t e;
        lb_t  f;
        @(negedge clk);
        if (cyc >= 1) begin
            if (mem_en) begin
                if (acc_q.size() == 0) begin
                    check("access_unexpected", 128'(mem_en), 128'(0));
                end else begin
                    e = acc_q.pop_front();
                    check("access", {16'(cyc), st_gnt, ld_gnt, mem_we, mem_addr, mem_wdata},
                          {16'(e.cyc), e.sg, e.lg, e.we, e.addr, e.wdata});
                end
            end else begin
                check("idle_port", {mem_we, st_gnt, ld_gnt}, 128'(0));
                if (acc_q.size() > 0 && acc_q[0].cyc <= cyc) begin
                    check("access_missing", 128'(mem_en), 128'(1));
                    void'(acc_q.pop_front());
                end
            end
            if (loadbus != 40'h0) begin
                if (lb_q.size() == 0) begin
                    check("loadbus_unexpected", 128'(loadbus), 128'(0));
                end else begin
                    f = lb_q.pop_front();
                    check("loadbus", {16'(cyc), loadbus}, {16'(f.cyc), f.val});
                end
            end else if (lb_q.size() > 0 && lb_q[0].cyc <= cyc) begin
                f = lb_q.pop_front();
                check("loadbus_missing", 128'(loadbus), 128'(f.val));
            end
            check("busy", 128'(busy), 128'(exp_busy[cyc]));
        end
    end

    initial begin
        rst = 1'b1;
        st_req = 2'b00; ld_req = 2'b00;
        for (int i = 0; i < 2; i++) begin
            s_addr[i] = 16'h0; l_addr[i] = 16'h0; s_data[i] = 32'h0; l_tag[i] = 8'h0;
        end
        model_reset();
        rst_req = 1'b1;
        repeat (3) step();
        rst_req = 1'b0;
        check("reset_outputs",
              {st_gnt, ld_gnt, mem_en, mem_we, mem_addr, mem_wdata, loadbus, busy}, 128'(0));

        // Store only, request dropped after the grant.
        put_st(0, 16'h0010, 32'hDEADBEEF);
        repeat (4) step();

        // Single load latency.
        mem_tab[16'h0040] = 32'h12345678;
        put_ld(0, 16'h0040, 8'h21);
        repeat (6) step();

        // Four-way arbitration from the reset state.
        rst_req = 1'b1; step(); rst_req = 1'b0;
        put_st(0, 16'h0100, 32'h11111111);
        put_ld(0, 16'h0200, 8'h07);
        put_st(1, 16'h0300, 32'h33333333);
        put_ld(1, 16'h0400, 8'h08);
        repeat (8) step();

        // Hazard with last served class = store.
        put_st(0, 16'h0500, 32'h55555555);
        step();
        put_st(1, 16'h0080, 32'h80808080);
        put_ld(0, 16'h0080, 8'h33);
        repeat (7) step();

        // Back-to-back loads.
        mem_tab[16'h0600] = 32'h0000000A;
        mem_tab[16'h0700] = 32'h0000000B;
        put_ld(0, 16'h0600, 8'h05);
        step();
        put_ld(1, 16'h0700, 8'h06);
        repeat (8) step();

        // Reset the cycle after a load grant.
        put_ld(0, 16'h0040, 8'h44);
        step();
        rst_req = 1'b1; step(); rst_req = 1'b0;
        step();
        check("midflight_reset_outputs",
              {st_gnt, ld_gnt, mem_en, mem_we, mem_addr, mem_wdata, loadbus, busy}, 128'(0));
        repeat (5) step();

        // Randomized traffic.
        rand_en = 1'b1;
        repeat (3000) step();
        rand_en = 1'b0;
        repeat (12) step();
        check("access_drain", 128'(acc_q.size()), 128'(0));
        check("loadbus_drain", 128'(lb_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
